elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
- Car-control FSM for the Elevator design; it sits at the requesting end of the Count timer interface.
- Latches floor-call requests and schedules car motion (up/down scan).
- Issues timer start requests: wait1n for per-floor travel, wait2n for door dwell.
- Consumes the timer done flags (wait1, wait2) to advance floor position and close the door.

Parameters:
- FLOORS, 4, number of floors served; floors are numbered 0..FLOORS-1.
- FLOOR_W, 2, width of the floor index; must satisfy 2**FLOOR_W >= FLOORS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req  input  FLOORS  floor-call buttons; level or pulse, sampled every clk.
- wait1  input  1  travel timer done (one floor traversed).
- wait2  input  1  door-dwell timer done.
- wait1n  output  1  travel timer start; one-cycle high pulse.
- wait2n  output  1  dwell timer start; one-cycle high pulse.
- floor  output  FLOOR_W  current car floor.
- up  output  1  car moving up.
- down  output  1  car moving down.
- door_open  output  1  door open.
- pending  output  FLOORS  latched, unserved calls.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, floor=0, dir=UP, pending=0.
  - wait1n, wait2n, up, down, door_open all 0.
  - Applies mid-operation: the car position is forced to 0, because the car has no position sensor.
- Registers: all outputs are registered.
- Pending register: each cycle, pending_next = pending | req, minus any bit cleared by the FSM. A clear on the same bit in the same cycle wins over the set.
- Scheduler (combinational), computed from pending and floor:
  - here = pending[floor].
  - above = any pending bit above floor.
  - below = any pending bit below floor.
- IDLE (decision state), checked in this priority order:
  1. here: go to DOOR; clear pending[floor]; pulse wait2n; set door_open=1.
  2. dir=UP and above (or dir=DOWN and below): go to MOVE in dir; pulse wait1n; assert up or down.
  3. Only the opposite side has calls: flip dir, then proceed as in 2.
  4. No calls: stay in IDLE with all outputs 0; dir is retained.
- MOVE:
  - up or down is held.
  - wait1 is ignored in the cycle wait1n is high.
  - On wait1: floor ±1, up/down cleared, go to IDLE. The decision takes one extra cycle.
  - Calls for the departed floor stay pending until served.
- DOOR:
  - door_open is held.
  - A call for the current floor arriving during dwell: clear that bit and re-pulse wait2n, which extends the dwell.
  - wait2 is ignored in the cycle wait2n is high.
  - On wait2: door_open cleared, go to IDLE.
- Done flags: wait1 or wait2 arriving in any other state is ignored.
- Floor limits:
  - floor never decrements below 0 or increments above FLOORS-1; the scheduler guarantees this.
  - Requests at bit indices >= FLOORS are unused.
- Latencies:
  - req to pending visible: 1 cycle.
  - IDLE decision to wait1n/wait2n pulse: same edge as the state change.
  - wait1 to floor update: 1 cycle.
- Simultaneous events:
  - Calls for floors above and below with dir=UP: above is served first.
  - wait1 and wait2 together: only the done flag for the current state acts.

Decomposition:
- Shared package elevator_pkg:
  - state encoding: IDLE, MOVE, DOOR.
  - direction constants: UP, DOWN.
  - defaults for FLOORS and FLOOR_W.
- Sub-module call_sched: combinational; inputs pending and floor; outputs here, above, below.
- elevator_ctrl holds the FSM, the pending register and the pulse generation.

Test Plan:
- Bench timer model: wait1 goes high 3 clocks after a wait1n pulse; wait2 goes high 6 clocks after a wait2n pulse.
- Reset: drive reset=0 mid-MOVE at floor 2 -> outputs immediately 0, floor=0, pending=0, state IDLE; after release, no motion without req.
- Local call: idle at floor 0, req=4'b0001 for 1 cycle -> pending=0001 -> next cycle door_open=1, wait2n high exactly 1 cycle, pending=0000; 6 clocks later wait2 -> door_open=0, IDLE.
- Travel: floor 0, req=4'b0100 -> up=1 with a wait1n pulse; floor=1 after the first wait1; a second wait1n pulse, then floor=2; door_open=1 at floor 2; exactly 2 wait1n pulses and 1 wait2n pulse.
- Scan order: at floor 2, dir=UP, pending=4'b1001 -> serves floor 3 first (door opens at 3), then reverses, down=1, arrives at floor 0; pending=0 at end.
- Dwell extend: door open at floor 1, req[1] pulsed 4 cycles into dwell -> second wait2n pulse, door_open stays 1 for 6 clocks after the re-pulse; pending[1] stays 0.
- Ignored done flags: inject wait1 while in DOOR and wait2 while in MOVE -> no state, floor or door change.

Source files
------------

// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator car controller:
//   - state_t : controller FSM states (IDLE decision, MOVE travel, DOOR dwell)
//   - dir_t   : scan direction (UP, DOWN)
//   - FLOORS_DEF / FLOOR_W_DEF : default floor count and floor-index width
// -----------------------------------------------------------------------------
package elevator_pkg;

    localparam int FLOORS_DEF  = 4;
    localparam int FLOOR_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/elevator_ctrl_if.sv
// -----------------------------------------------------------------------------
// elevator_ctrl_if
// Count-timer handshake between the car controller and the timer block.
//   wait1n : travel timer start pulse   (controller -> timer)
//   wait2n : dwell timer start pulse    (controller -> timer)
//   wait1  : travel timer done          (timer -> controller)
//   wait2  : dwell timer done           (timer -> controller)
// Modports:
//   master : controller side (drives the start pulses, receives done flags)
//   slave  : timer side
// -----------------------------------------------------------------------------
interface elevator_ctrl_if;

    logic wait1n;
    logic wait2n;
    logic wait1;
    logic wait2;

    modport master (
        output wait1n,
        output wait2n,
        input  wait1,
        input  wait2
    );

    modport slave (
        input  wait1n,
        input  wait2n,
        output wait1,
        output wait2
    );

endinterface

// File: rtl/elevator_ctrl_call_sched.sv
// -----------------------------------------------------------------------------
// call_sched
// Combinational call scheduler. Classifies the latched calls relative to the
// current car position.
// Ports:
//   pending : latched floor calls, one bit per floor
//   floor   : current car floor
//   here    : a call is latched for the current floor
//   above   : a call is latched for some floor above the car
//   below   : a call is latched for some floor below the car
// -----------------------------------------------------------------------------
module call_sched
    import elevator_pkg::*;
#(
    parameter int FLOORS  = FLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
) (
    input  logic [FLOORS-1:0]  pending,
    input  logic [FLOOR_W-1:0] floor,
    output logic               here,
    output logic               above,
    output logic               below
);

    // Split the pending vector into the car's floor, floors above and below.
    always_comb begin
        here  = 1'b0;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) > floor) begin
                above = above | pending[i];
            end else if (FLOOR_W'(i) < floor) begin
                below = below | pending[i];
            end else begin
                here = here | pending[i];
            end
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_ctrl
// Elevator car-control FSM. Latches floor calls, runs an up/down scan, starts
// the travel timer (wait1n) once per floor and the door-dwell timer (wait2n)
// at each stop, and advances on the timer done flags.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   req       : floor-call buttons (level or pulse)
//   tmr       : timer handshake (master side: wait1n/wait2n out, wait1/wait2 in)
//   floor     : current car floor
//   up, down  : car moving up / down
//   door_open : door open
//   pending   : latched, unserved calls
// All outputs are registered.
// -----------------------------------------------------------------------------
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS  = FLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [FLOORS-1:0]   req,
    elevator_ctrl_if.master     tmr,
    output logic [FLOOR_W-1:0]  floor,
    output logic                up,
    output logic                down,
    output logic                door_open,
    output logic [FLOORS-1:0]   pending
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOT_FLOOR = {FLOOR_W{1'b0}};

    state_t               state_r;
    dir_t                 dir_r;
    logic [FLOOR_W-1:0]   floor_r;
    logic [FLOORS-1:0]    pending_r;
    logic                 wait1n_r;
    logic                 wait2n_r;
    logic                 up_r;
    logic                 down_r;
    logic                 door_open_r;

    logic                 here_s;
    logic                 above_s;
    logic                 below_s;
    logic [FLOORS-1:0]    floor_mask_s;
    logic [FLOORS-1:0]    clr_s;
    logic                 call_here_s;

    call_sched #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_call_sched (
        .pending (pending_r),
        .floor   (floor_r),
        .here    (here_s),
        .above   (above_s),
        .below   (below_s)
    );

    // One-hot mask selecting the car's current floor in the call vector.
    always_comb begin
        floor_mask_s = {FLOORS{1'b0}};
        for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) == floor_r) begin
                floor_mask_s[i] = 1'b1;
            end else begin
                floor_mask_s[i] = 1'b0;
            end
        end
    end

    // A call for this floor during dwell is taken straight from req so it is
    // absorbed in the same cycle and never shows up in pending.
    assign call_here_s = |((pending_r | req) & floor_mask_s);

    // Calls served this cycle; a clear beats a simultaneous set on the same bit.
    always_comb begin
        clr_s = {FLOORS{1'b0}};
        case (state_r)
            IDLE: begin
                if (here_s) begin
                    clr_s = floor_mask_s;
                end else begin
                    clr_s = {FLOORS{1'b0}};
                end
            end
            DOOR: begin
                if (call_here_s) begin
                    clr_s = floor_mask_s;
                end else begin
                    clr_s = {FLOORS{1'b0}};
                end
            end
            default: begin
                clr_s = {FLOORS{1'b0}};
            end
        endcase
    end

    // Controller FSM with call latch, position tracking and timer-start pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            dir_r       <= UP;
            floor_r     <= BOT_FLOOR;
            pending_r   <= {FLOORS{1'b0}};
            wait1n_r    <= 1'b0;
            wait2n_r    <= 1'b0;
            up_r        <= 1'b0;
            down_r      <= 1'b0;
            door_open_r <= 1'b0;
        end else begin
            pending_r <= (pending_r | req) & ~clr_s;
            // Start pulses last exactly one cycle unless re-armed below.
            wait1n_r  <= 1'b0;
            wait2n_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (here_s) begin
                        state_r     <= DOOR;
                        wait2n_r    <= 1'b1;
                        door_open_r <= 1'b1;
                    end else if ((dir_r == UP) && above_s) begin
                        state_r  <= MOVE;
                        wait1n_r <= 1'b1;
                        up_r     <= 1'b1;
                    end else if ((dir_r == DOWN) && below_s) begin
                        state_r  <= MOVE;
                        wait1n_r <= 1'b1;
                        down_r   <= 1'b1;
                    end else if (above_s) begin
                        dir_r    <= UP;
                        state_r  <= MOVE;
                        wait1n_r <= 1'b1;
                        up_r     <= 1'b1;
                    end else if (below_s) begin
                        dir_r    <= DOWN;
                        state_r  <= MOVE;
                        wait1n_r <= 1'b1;
                        down_r   <= 1'b1;
                    end else begin
                        up_r        <= 1'b0;
                        down_r      <= 1'b0;
                        door_open_r <= 1'b0;
                    end
                end
                MOVE: begin
                    // A done flag coinciding with our own start pulse belongs
                    // to a previous timer run and is ignored.
                    if (tmr.wait1 && !wait1n_r) begin
                        if (up_r && (floor_r != TOP_FLOOR)) begin
                            floor_r <= floor_r + FLOOR_W'(1);
                        end else if (down_r && (floor_r != BOT_FLOOR)) begin
                            floor_r <= floor_r - FLOOR_W'(1);
                        end else begin
                            floor_r <= floor_r;
                        end
                        up_r    <= 1'b0;
                        down_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        up_r   <= up_r;
                        down_r <= down_r;
                    end
                end
                DOOR: begin
                    // A fresh call here restarts the dwell timer.
                    if (call_here_s) begin
                        wait2n_r <= 1'b1;
                    end else if (tmr.wait2 && !wait2n_r) begin
                        door_open_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        door_open_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    up_r        <= 1'b0;
                    down_r      <= 1'b0;
                    door_open_r <= 1'b0;
                end
            endcase
        end
    end

    assign tmr.wait1n = wait1n_r;
    assign tmr.wait2n = wait2n_r;
    assign floor      = floor_r;
    assign up         = up_r;
    assign down       = down_r;
    assign door_open  = door_open_r;
    assign pending    = pending_r;

endmodule

// File: tb/tb_elevator_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_ctrl
// Self-checking bench for elevator_ctrl. A timer model answers wait1n after 3
// clocks and wait2n after 6 clocks (retriggerable). Expected stop floors are
// queued when calls are issued and compared when the door opens.
// -----------------------------------------------------------------------------
module tb_elevator_ctrl;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [1:0] floor;
    logic       up;
    logic       down;
    logic       door_open;
    logic [3:0] pending;

    elevator_ctrl_if tmr_if ();

    logic m1 = 1'b0, m2 = 1'b0, inj1 = 1'b0, inj2 = 1'b0;
    int   cnt1 = 0, cnt2 = 0;

    assign tmr_if.wait1 = m1 | inj1;
    assign tmr_if.wait2 = m2 | inj2;

    elevator_ctrl #(.FLOORS(4), .FLOOR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .tmr       (tmr_if),
        .floor     (floor),
        .up        (up),
        .down      (down),
        .door_open (door_open),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timer model: done flag seen by the DUT 3 (travel) / 6 (dwell) edges after the start pulse.
    always @(negedge clk) begin
        if (cnt1 > 0) cnt1 = cnt1 - 1;
        if (tmr_if.wait1n) cnt1 = 3;
        m1 = (cnt1 == 1);
        if (cnt2 > 0) cnt2 = cnt2 - 1;
        if (tmr_if.wait2n) cnt2 = 6;
        m2 = (cnt2 == 1);
    end

    // Scoreboard monitor: pulse widths/counts and stop floors.
    int         w1n_cnt = 0, w2n_cnt = 0;
    logic       prev_w1n = 1'b0, prev_w2n = 1'b0, prev_door = 1'b0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_floor;

    always @(negedge clk) begin
        if (tmr_if.wait1n) begin
            w1n_cnt++;
            check("wait1n_single_cycle", {31'd0, prev_w1n}, 32'd0);
        end
        if (tmr_if.wait2n) begin
            w2n_cnt++;
            check("wait2n_single_cycle", {31'd0, prev_w2n}, 32'd0);
        end
        if (door_open && !prev_door) begin
            check("stop_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_floor = exp_q.pop_front();
                check("stop_floor", {30'd0, floor}, {30'd0, exp_floor});
            end
        end
        prev_w1n  = tmr_if.wait1n;
        prev_w2n  = tmr_if.wait2n;
        prev_door = door_open;
    end

    task automatic pulse_req(input logic [3:0] r);
        req = r;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic wait_quiet(input string name, input int max);
        int n = 0;
        while (!(pending == 4'b0000 && !up && !down && !door_open) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_quiet_timeout"}, {31'd0, (n < max)}, 32'd1);
    endtask

    task automatic wait_door(input string name, input int max);
        int n = 0;
        while (!door_open && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_door_timeout"}, {31'd0, (n < max)}, 32'd1);
    endtask

    typedef struct {
        logic [3:0] req;
        int         nstops;
        logic [1:0] stop0;
        logic [1:0] stop1;
        int         w1n;
        int         w2n;
        logic [1:0] final_floor;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, n;

        // Each vector starts where the previous one left the car.
        vecs[0] = '{4'b0001, 1, 2'd0, 2'd0, 0, 1, 2'd0}; // call at own floor
        vecs[1] = '{4'b0100, 1, 2'd2, 2'd0, 2, 1, 2'd2}; // travel 0 -> 2
        vecs[2] = '{4'b1001, 2, 2'd3, 2'd0, 4, 2, 2'd0}; // scan up first, then reverse
        vecs[3] = '{4'b0010, 1, 2'd1, 2'd0, 1, 1, 2'd1}; // dir DOWN, only above -> flip
        vecs[4] = '{4'b0101, 2, 2'd2, 2'd0, 3, 2, 2'd0}; // above beats below with UP
        vecs[5] = '{4'b1000, 1, 2'd3, 2'd0, 3, 1, 2'd3}; // full travel to top
        vecs[6] = '{4'b0011, 2, 2'd1, 2'd0, 3, 2, 2'd0}; // from top, scan down
        vecs[7] = '{4'b0000, 0, 2'd0, 2'd0, 0, 0, 2'd0}; // no calls, stay idle

        // Reset state, with calls presented while held in reset.
        reset = 1'b0;
        req   = 4'b0101;
        repeat (3) @(negedge clk);
        check("rst_floor",     {30'd0, floor}, 32'd0);
        check("rst_up",        {31'd0, up}, 32'd0);
        check("rst_down",      {31'd0, down}, 32'd0);
        check("rst_door",      {31'd0, door_open}, 32'd0);
        check("rst_pending",   {28'd0, pending}, 32'd0);
        check("rst_wait1n",    {31'd0, tmr_if.wait1n}, 32'd0);
        check("rst_wait2n",    {31'd0, tmr_if.wait2n}, 32'd0);
        req   = 4'b0000;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven trips.
        for (int v = 0; v < 8; v++) begin
            s1 = w1n_cnt;
            s2 = w2n_cnt;
            if (vecs[v].nstops > 0) exp_q.push_back(vecs[v].stop0);
            if (vecs[v].nstops > 1) exp_q.push_back(vecs[v].stop1);
            pulse_req(vecs[v].req);
            wait_quiet($sformatf("vec%0d", v), 400);
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_wait1n_count", v), w1n_cnt - s1, vecs[v].w1n);
            check($sformatf("vec%0d_wait2n_count", v), w2n_cnt - s2, vecs[v].w2n);
            check($sformatf("vec%0d_final_floor", v), {30'd0, floor}, {30'd0, vecs[v].final_floor});
            check($sformatf("vec%0d_stops_left", v), exp_q.size(), 32'd0);
        end

        // Local call cycle by cycle (car idle at floor 0).
        exp_q.push_back(2'd0);
        pulse_req(4'b0001);
        check("local_pending_set", {28'd0, pending}, 32'h1);
        check("local_door_not_yet", {31'd0, door_open}, 32'd0);
        @(negedge clk);
        check("local_door_open", {31'd0, door_open}, 32'd1);
        check("local_wait2n", {31'd0, tmr_if.wait2n}, 32'd1);
        check("local_pending_clr", {28'd0, pending}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("local_dwell%0d_door", i), {31'd0, door_open}, 32'd1);
            check($sformatf("local_dwell%0d_wait2n", i), {31'd0, tmr_if.wait2n}, 32'd0);
        end
        @(negedge clk);
        check("local_door_closed", {31'd0, door_open}, 32'd0);
        repeat (2) @(negedge clk);

        // Dwell extension at floor 1.
        s2 = w2n_cnt;
        exp_q.push_back(2'd1);
        pulse_req(4'b0010);
        wait_door("dwell_arrive", 100);
        check("dwell_first_wait2n", {31'd0, tmr_if.wait2n}, 32'd1);
        repeat (3) @(negedge clk);
        check("dwell_pre_extend_door", {31'd0, door_open}, 32'd1);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        check("dwell_repulse", {31'd0, tmr_if.wait2n}, 32'd1);
        check("dwell_pending_clear", {28'd0, pending}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("dwell_ext%0d_door", i), {31'd0, door_open}, 32'd1);
            check($sformatf("dwell_ext%0d_pend1", i), {31'd0, pending[1]}, 32'd0);
        end
        @(negedge clk);
        check("dwell_door_closed", {31'd0, door_open}, 32'd0);
        check("dwell_wait2n_count", w2n_cnt - s2, 32'd2);
        wait_quiet("dwell", 50);

        // Done flags in the wrong state or in the start-pulse cycle are ignored.
        exp_q.push_back(2'd0);
        pulse_req(4'b0001);
        @(negedge clk);
        check("ign_moving_down", {31'd0, down}, 32'd1);
        check("ign_wait1n", {31'd0, tmr_if.wait1n}, 32'd1);
        inj1 = 1'b1;
        @(negedge clk);
        inj1 = 1'b0;
        check("ign_w1_in_pulse_floor", {30'd0, floor}, 32'd1);
        check("ign_w1_in_pulse_down", {31'd0, down}, 32'd1);
        inj2 = 1'b1;
        @(negedge clk);
        inj2 = 1'b0;
        check("ign_w2_in_move_floor", {30'd0, floor}, 32'd1);
        check("ign_w2_in_move_down", {31'd0, down}, 32'd1);
        check("ign_w2_in_move_door", {31'd0, door_open}, 32'd0);
        wait_door("ign_arrive", 50);
        inj1 = 1'b1;
        inj2 = 1'b1;
        @(negedge clk);
        inj1 = 1'b0;
        inj2 = 1'b0;
        check("ign_both_in_pulse_door", {31'd0, door_open}, 32'd1);
        check("ign_both_in_pulse_floor", {30'd0, floor}, 32'd0);
        check("ign_both_in_pulse_motion", {30'd0, up, down}, 32'd0);
        inj1 = 1'b1;
        @(negedge clk);
        inj1 = 1'b0;
        check("ign_w1_in_door_door", {31'd0, door_open}, 32'd1);
        check("ign_w1_in_door_floor", {30'd0, floor}, 32'd0);
        wait_quiet("ign", 50);

        // Reset while moving up out of floor 2.
        pulse_req(4'b1000);
        n = 0;
        while (!(floor == 2'd2 && up) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_floor2", {31'd0, (n < 100)}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_floor", {30'd0, floor}, 32'd0);
        check("midrst_up", {31'd0, up}, 32'd0);
        check("midrst_down", {31'd0, down}, 32'd0);
        check("midrst_door", {31'd0, door_open}, 32'd0);
        check("midrst_pending", {28'd0, pending}, 32'd0);
        check("midrst_pulses", {30'd0, tmr_if.wait1n, tmr_if.wait2n}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("postrst%0d_still", i),
                  {23'd0, floor, up, down, door_open, tmr_if.wait1n, tmr_if.wait2n, pending},
                  32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
